// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into click / double-click / long-press events.
// Define AUTO_REPEAT_EN to add periodic repeat_pulse while the button stays held past a long press.
module button_event_decoder #(
  parameter int LONG_PRESS_CLK_CNT   = 4194304,
  parameter int DOUBLE_CLICK_CLK_CNT = 2097152,
  parameter int REPEAT_CLK_CNT       = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_debounced,
  output logic click_pulse,
  output logic double_click_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse,
  output logic btn_held
);

  // One counter serves every state, so it is sized for the largest interval (all params >= 2).
  localparam int MAX_CNT = (LONG_PRESS_CLK_CNT > DOUBLE_CLICK_CLK_CNT) ?
                           ((LONG_PRESS_CLK_CNT > REPEAT_CLK_CNT) ? LONG_PRESS_CLK_CNT : REPEAT_CLK_CNT) :
                           ((DOUBLE_CLICK_CLK_CNT > REPEAT_CLK_CNT) ? DOUBLE_CLICK_CLK_CNT : REPEAT_CLK_CNT);
  localparam int CW = $clog2(MAX_CNT);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CLK_CNT - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DOUBLE_CLICK_CLK_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    RELEASE_WAIT,
    PRESS2,
    LONG_HELD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          click_nxt, dbl_nxt, long_nxt;

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CLK_CNT - 1);
  logic rep_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      cnt                <= '0;
      click_pulse        <= 1'b0;
      double_click_pulse <= 1'b0;
      long_press_pulse   <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      click_pulse        <= click_nxt;
      double_click_pulse <= dbl_nxt;
      long_press_pulse   <= long_nxt;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) repeat_pulse <= 1'b0;
    else        repeat_pulse <= rep_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  assign btn_held = (state == LONG_HELD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_nxt   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (btn_debounced) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (!btn_debounced) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // Window expiry wins over a coincident press; IDLE picks that press up next edge.
        if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          click_nxt = 1'b1;
        end else if (btn_debounced) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (!btn_debounced) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dbl_nxt   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_debounced) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == REP_LAST) begin
          cnt_nxt = '0;
          rep_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, DBL=4, REPEAT=3.
// Output vector order: {click, double_click, long_press, repeat, held}.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic click_pulse, double_click_pulse, long_press_pulse, repeat_pulse, btn_held;

  int nvec = 0;
  int nerr = 0;

  localparam logic [4:0] Z    = 5'b00000;
  localparam logic [4:0] CLK1 = 5'b10000;
  localparam logic [4:0] DBL  = 5'b01000;
  localparam logic [4:0] LNG  = 5'b00101;
  localparam logic [4:0] HLD  = 5'b00001;
  localparam logic [4:0] REP  = 5'b00011;

  button_event_decoder #(
    .LONG_PRESS_CLK_CNT  (8),
    .DOUBLE_CLICK_CLK_CNT(4),
    .REPEAT_CLK_CNT      (3)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_debounced     (btn),
    .click_pulse       (click_pulse),
    .double_click_pulse(double_click_pulse),
    .long_press_pulse  (long_press_pulse),
    .repeat_pulse      (repeat_pulse),
    .btn_held          (btn_held)
  );

  always #5 clk = ~clk;

  // Drive btn, take one edge, then check the outputs that edge produced.
  task automatic t(input logic b, input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    btn = b;
    @(posedge clk);
    #1;
    obs = {click_pulse, double_click_pulse, long_press_pulse, repeat_pulse, btn_held};
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tn(input logic b, input int n, input logic [4:0] exp, input string tag);
    for (int i = 0; i < n; i++) t(b, exp, tag);
  endtask

  initial begin
    reset = 1'b0;
    tn(1'b0, 2, Z, "reset_state");
    reset = 1'b1;
    tn(1'b0, 2, Z, "idle");

    // Single click: high 3, release at R, click visible after R+4.
    tn(1'b1, 3, Z, "click_press");
    t (1'b0, Z, "click_release");
    tn(1'b0, 3, Z, "click_window");
    t (1'b0, CLK1, "click_pulse");
    tn(1'b0, 6, Z, "click_after");

    // Double click: high 3, low 2, high 3, low.
    tn(1'b1, 3, Z, "dbl_press1");
    tn(1'b0, 2, Z, "dbl_gap");
    tn(1'b1, 3, Z, "dbl_press2");
    t (1'b0, DBL, "dbl_pulse");
    tn(1'b0, 7, Z, "dbl_no_click");

    // Long press: pulse after the 9th high edge, then held (+repeat every 3).
    tn(1'b1, 8, Z, "long_count");
    t (1'b1, LNG, "long_pulse");
    for (int i = 1; i <= 11; i++) begin
`ifdef AUTO_REPEAT_EN
      t(1'b1, (i % 3 == 0) ? REP : HLD, "long_held");
`else
      t(1'b1, HLD, "long_held");
`endif
    end
    t (1'b0, Z, "long_release");
    tn(1'b0, 6, Z, "long_no_click");

    // Second press becomes a long press: no click, no double.
    t (1'b1, Z, "p2l_press1");
    t (1'b0, Z, "p2l_release");
    t (1'b1, Z, "p2l_enter_p2");
    tn(1'b1, 7, Z, "p2l_count");
    t (1'b1, LNG, "p2l_long");
    t (1'b0, Z, "p2l_release2");
    tn(1'b0, 6, Z, "p2l_quiet");

    // Press coincident with window expiry: click first, then a fresh PRESS1.
    tn(1'b1, 2, Z, "exp_press");
    t (1'b0, Z, "exp_release");
    tn(1'b0, 3, Z, "exp_window");
    t (1'b1, CLK1, "exp_click");
    t (1'b1, Z, "exp_new_press");
    t (1'b0, Z, "exp_new_release");
    tn(1'b0, 3, Z, "exp_new_window");
    t (1'b0, CLK1, "exp_new_click");
    tn(1'b0, 3, Z, "exp_quiet");

    // Reset while in RELEASE_WAIT swallows the pending click.
    tn(1'b1, 2, Z, "rst_rw_press");
    tn(1'b0, 2, Z, "rst_rw_wait");
    reset = 1'b0;
    t (1'b0, Z, "rst_rw_reset");
    reset = 1'b1;
    tn(1'b0, 6, Z, "rst_rw_quiet");

    // Reset while in LONG_HELD, button held through release: long press restarts.
    tn(1'b1, 8, Z, "rst_lh_count");
    t (1'b1, LNG, "rst_lh_long");
    t (1'b1, HLD, "rst_lh_held");
    reset = 1'b0;
    t (1'b1, Z, "rst_lh_reset");
    reset = 1'b1;
    tn(1'b1, 8, Z, "rst_lh_recount");
    t (1'b1, LNG, "rst_lh_relong");
    t (1'b0, Z, "rst_lh_release");
    tn(1'b0, 6, Z, "rst_lh_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
